cordic_rotate: RTL

//  Iterative rotation-mode CORDIC. Rotates one 2D point (x_in, y_in) by angle_in and returns (x_out, y_out).

---
 rtl/cordic_rotate_if.sv | 27 ++
 rtl/cordic_rotate.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/cordic_rotate_if.sv
`timescale 1ns/1ps
// Handshake bundle for cordic_rotate: valid/ready request side carrying (x, y, angle),
// valid/ready response side carrying the rotated (x, y), plus a busy indicator.
interface cordic_rotate_if #(
    parameter int W = 32
);
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic signed [W-1:0] angle_in;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] x_out;
    logic signed [W-1:0] y_out;
    logic                busy;

    modport slave (
        input  in_valid, x_in, y_in, angle_in, out_ready,
        output in_ready, out_valid, x_out, y_out, busy
    );

    modport master (
        output in_valid, x_in, y_in, angle_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, busy
    );
endinterface

// File: rtl/cordic_rotate.sv
`timescale 1ns/1ps
// Iterative rotation-mode CORDIC with quadrant pre-rotation and gain compensation.
// Latency: out_valid rises N_ITER+2 edges after the accepting edge; one transaction in flight.
// Backpressure: result held in DONE until out_ready; in_ready is high only in IDLE.
module cordic_rotate #(
    parameter int W      = 32,
    parameter int FRAC   = 24,
    parameter int N_ITER = 24
) (
    input  logic            clock,
    input  logic            reset,
    cordic_rotate_if.slave  bus
);
    localparam int CW = $clog2(N_ITER);

    localparam logic signed [W-1:0]   PI_2   = W'(26353589);
    localparam logic signed [W-1:0]   NPI_2  = -PI_2;
    localparam logic signed [2*W-1:0] K_GAIN = (2*W)'(10188013);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREROT,
        S_ITER,
        S_SCALE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic signed [W-1:0] x_q, x_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] z_q, z_d;
    logic [CW-1:0]       count_q, count_d;
    logic signed [W-1:0] x_out_q, x_out_d;
    logic signed [W-1:0] y_out_q, y_out_d;
    logic                out_valid_q, out_valid_d;

    logic signed [W-1:0] x_sh, y_sh, atan_i;

    function automatic logic signed [W-1:0] atan_lut(input logic [4:0] i);
        int v;
        case (i)
            5'd0:    v = 13176795;
            5'd1:    v = 7778716;
            5'd2:    v = 4110060;
            5'd3:    v = 2086331;
            5'd4:    v = 1047214;
            5'd5:    v = 524117;
            5'd6:    v = 262123;
            5'd7:    v = 131069;
            5'd8:    v = 65536;
            5'd9:    v = 32768;
            5'd10:   v = 16384;
            5'd11:   v = 8192;
            5'd12:   v = 4096;
            5'd13:   v = 2048;
            5'd14:   v = 1024;
            5'd15:   v = 512;
            5'd16:   v = 256;
            5'd17:   v = 128;
            5'd18:   v = 64;
            5'd19:   v = 32;
            5'd20:   v = 16;
            5'd21:   v = 8;
            5'd22:   v = 4;
            5'd23:   v = 2;
            default: v = 0;
        endcase
        return W'(v);
    endfunction

    always_comb begin
        x_sh   = x_q >>> count_q;
        y_sh   = y_q >>> count_q;
        atan_i = atan_lut(5'(count_q));
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        count_d     = count_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.x_in;
                    y_d     = bus.y_in;
                    z_d     = bus.angle_in;
                    state_d = S_PREROT;
                end
            end
            S_PREROT: begin
                // Fold the angle into the +/-pi/2 convergence range with an exact 90-degree turn.
                if (z_q > PI_2) begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = z_q - PI_2;
                end else if (z_q < NPI_2) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = z_q + PI_2;
                end
                count_d = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (!z_q[W-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(N_ITER - 1)) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                x_out_d     = W'(($signed({{W{x_q[W-1]}}, x_q}) * K_GAIN) >>> FRAC);
                y_out_d     = W'(($signed({{W{y_q[W-1]}}, y_q}) * K_GAIN) >>> FRAC);
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            count_q     <= '0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            count_q     <= count_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_out_q;
    assign bus.y_out     = y_out_q;
endmodule
